gin_tag_sequencer: RTL and testbench
====================================

# gin_tag_sequencer

Upstream source stage for the global input network (GIN) column bus. It accepts a stream of data words from the global buffer, buffers them in a small FIFO, and stamps each word with a row/column destination tag. Tags walk a programmed rows × cols frame in row-major order. Each word is presented to the GIN with an enable/ready handshake, and `done` pulses when the frame is complete.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of one data word
- `ROW_TAG_WIDTH`, 4, width of row tag and of `cfg_rows`
- `COL_TAG_WIDTH`, 4, width of column tag and of `cfg_cols`
- `NUM_OF_ROWS`, 12, maximum rows per frame
- `NUM_OF_COLS`, 14, maximum columns per frame
- `FIFO_DEPTH`, 4, buffer entries; must be a power of 2, ≥ 2

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: frame start request, sampled only in IDLE
- `cfg_rows` in ROW_TAG_WIDTH: row count of the frame
- `cfg_cols` in COL_TAG_WIDTH: column count of the frame
- `in_data` in DATA_WIDTH: word from the global buffer
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: block accepts `in_data` this cycle
- `data_out` out DATA_WIDTH: word to the GIN
- `row_tag` out ROW_TAG_WIDTH: destination row of `data_out`
- `col_tag` out COL_TAG_WIDTH: destination column of `data_out`
- `enable_out` out 1: `data_out` and tags valid
- `ready_in` in 1: aggregated GIN ready for the presented tag
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse after the last transfer of a frame

## Operation
- States: IDLE and RUN.
- IDLE:
  - `start`=1 latches the effective row and column counts. The effective count is `min(cfg, NUM_OF_ROWS)` for rows and `min(cfg, NUM_OF_COLS)` for columns.
  - If both effective counts are nonzero, the state goes to RUN.
  - If either effective count is 0, the state stays IDLE and `done` pulses on the next cycle.
- RUN:
  - `start` is ignored; `busy`=1.
- Input accept: `in_ready` = RUN && FIFO not full && accepted < rows·cols. A push happens when `in_valid && in_ready`. Words beyond the frame size are never accepted.
- Output present: `enable_out` = RUN && FIFO not empty.
  - `data_out` = FIFO head when `enable_out`=1, otherwise 0.
  - A transfer happens when `enable_out && ready_in`. It pops the FIFO and advances the tags.
- Tag walk:
  - Tags start at `row_tag`=0, `col_tag`=0.
  - On each transfer, `col_tag` increments. On the transfer at `col_tag`=cols−1, `col_tag` wraps to 0 and `row_tag` increments.
- Frame end:
  - The transfer at (rows−1, cols−1) moves the state to IDLE on the next edge.
  - At that edge, `done`=1 for exactly one cycle, the tags clear to 0, and the accept counter clears to 0.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured.
  - When the FIFO is full, no push occurs even if a pop occurs in the same cycle, because `in_ready` is already 0.
- Arithmetic:
  - Accept counter and transfer counter are ROW_TAG_WIDTH+COL_TAG_WIDTH bits wide and unsigned.
  - Clamp comparisons are unsigned.
- Reset, asynchronous at any time including mid-frame:
  - State = IDLE.
  - FIFO is emptied; pointers and counters are 0.
  - All outputs are 0: `in_ready`, `data_out`, `row_tag`, `col_tag`, `enable_out`, `busy`, `done`.

## Timing
- `start` at edge N (IDLE) → RUN and `busy`=1 after edge N; `in_ready` can be 1 in cycle N+1.
- Word accepted at edge M → `enable_out`=1 in cycle M+1 (one-cycle fall-through latency through the registered FIFO). There is no combinational path from `in_valid` to `enable_out`.
- `ready_in` feeds only the pop and the tag update; there is no combinational path from `ready_in` to `in_ready`.
- Back-to-back throughput is one transfer per cycle when `in_valid` and `ready_in` are held high.
- Last transfer at edge L → `done`=1 and `busy`=0 in cycle L+1, `done`=0 in cycle L+2. A new `start` is accepted in cycle L+1.
- `ready_in` low holds `data_out` and the tags stable. `enable_out` stays 1 while the FIFO is non-empty.

## Test plan
- Basic frame: `cfg_rows`=2, `cfg_cols`=3; `in_valid`=1 with data 0..5; `ready_in`=1 → tag sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) with data 0..5, then a one-cycle `done` and `busy`=0.
- Backpressure: `cfg_rows`=1, `cfg_cols`=14, `ready_in`=0 for the first 10 cycles → exactly FIFO_DEPTH=4 words accepted, `in_ready`=0 while full. Tag (0,0) and data 0 held stable. After `ready_in`=1, 14 transfers complete in order with `col_tag` 0..13.
- Frame-size cap: `cfg_rows`=1, `cfg_cols`=2, `in_valid` held 1 with 5 words available → only 2 words accepted. `in_ready` stays 0 after the 2nd accept. `done` pulses after the 2nd transfer.
- Clamp/zero: `cfg_rows`=15, `cfg_cols`=15 → 168 transfers with final tag (11,13). `cfg_cols`=0 → no `enable_out`, `done` pulses the cycle after `start`.
- Mid-frame reset: assert `reset` after 3 transfers of a 2×3 frame → all outputs 0 immediately and the FIFO is empty. A subsequent `start` restarts from tag (0,0).
- Start while busy: pulse `start` with new cfg during RUN → ignored; the current frame finishes with its original counts.

Source files
------------

// File: rtl/gin_tag_sequencer.sv
// gin_tag_sequencer: buffers global-buffer words in a small FIFO and presents
// them to the GIN column bus stamped with row-major (row, col) destination tags.
module gin_tag_sequencer #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned NUM_OF_ROWS   = 12,
  parameter int unsigned NUM_OF_COLS   = 14,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_rows,
  input  logic [COL_TAG_WIDTH-1:0] cfg_cols,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [ROW_TAG_WIDTH-1:0] row_tag,
  output logic [COL_TAG_WIDTH-1:0] col_tag,
  output logic                     enable_out,
  input  logic                     ready_in,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W  = ROW_TAG_WIDTH + COL_TAG_WIDTH;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_d;
  logic [ROW_TAG_WIDTH-1:0] rows_q, rows_eff, row_q;
  logic [COL_TAG_WIDTH-1:0] cols_q, cols_eff, col_q;
  logic [CNT_W-1:0]         acc_cnt_q, xfer_cnt_q, total;
  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic                     done_q;
  logic                     fifo_empty, fifo_full;
  logic                     push, pop, last_xfer, cfg_load, zero_start;

  // Clamp requested frame size to the physical array and derive frame length.
  always_comb begin
    rows_eff = (cfg_rows > ROW_TAG_WIDTH'(NUM_OF_ROWS)) ? ROW_TAG_WIDTH'(NUM_OF_ROWS) : cfg_rows;
    cols_eff = (cfg_cols > COL_TAG_WIDTH'(NUM_OF_COLS)) ? COL_TAG_WIDTH'(NUM_OF_COLS) : cfg_cols;
    total    = CNT_W'(rows_q) * CNT_W'(cols_q);
  end

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                      (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, handshakes and FIFO head presentation.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    enable_out = 1'b0;
    data_out   = '0;
    push       = 1'b0;
    pop        = 1'b0;
    last_xfer  = 1'b0;
    cfg_load   = 1'b0;
    zero_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_load = 1'b1;
          if ((rows_eff != '0) && (cols_eff != '0)) state_d = RUN;
          else                                      zero_start = 1'b1;
        end
      end
      RUN: begin
        in_ready   = !fifo_full && (acc_cnt_q < total);
        enable_out = !fifo_empty;
        if (enable_out) data_out = mem[rd_ptr_q[ADDR_W-1:0]];
        push       = in_valid && in_ready;
        pop        = enable_out && ready_in;
        last_xfer  = pop && (xfer_cnt_q == total - CNT_W'(1));
        if (last_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration, counters, tag walk, FIFO pointers and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_cnt_q  <= '0;
      xfer_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_xfer || zero_start;
      if (cfg_load) begin
        rows_q <= rows_eff;
        cols_q <= cols_eff;
      end
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (last_xfer) begin
        row_q      <= '0;
        col_q      <= '0;
        acc_cnt_q  <= '0;
        xfer_cnt_q <= '0;
      end else if (pop) begin
        xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        if (col_q == cols_q - COL_TAG_WIDTH'(1)) begin
          col_q <= '0;
          row_q <= row_q + ROW_TAG_WIDTH'(1);
        end else begin
          col_q <= col_q + COL_TAG_WIDTH'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= in_data;
  end

  assign row_tag = row_q;
  assign col_tag = col_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_gin_tag_sequencer.sv
// Scoreboard bench for gin_tag_sequencer: directed frames push expected
// (data, row, col) entries; a negedge monitor pops and compares each transfer.
module tb_gin_tag_sequencer;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  row;
    logic [3:0]  col;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_rows = '0;
  logic [3:0]  cfg_cols = '0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_out;
  logic [3:0]  row_tag;
  logic [3:0]  col_tag;
  logic        enable_out;
  logic        ready_in = 1'b0;
  logic        busy;
  logic        done;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mon_xfers = 0;
  int   done_cnt = 0;
  int   acc_count = 0;
  int   overrun = 0;
  logic [3:0] last_row = '0;
  logic [3:0] last_col = '0;

  gin_tag_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .row_tag(row_tag), .col_tag(col_tag), .enable_out(enable_out), .ready_in(ready_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && enable_out && ready_in) begin
      exp_t e;
      mon_xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_count", 64'(mon_xfers), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", data_out, e.data);
        chk("xfer_row", 64'(row_tag), 64'(e.row));
        chk("xfer_col", 64'(col_tag), 64'(e.col));
        last_row = row_tag;
        last_col = col_tag;
      end
    end else if (!reset && !enable_out) begin
      chk("idle_data_zero", data_out, 64'(0));
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic push_exp(input int er, input int ec, input logic [63:0] base);
    for (int k = 0; k < er * ec; k++) begin
      exp_t e;
      e.data = base + 64'(k);
      e.row  = 4'(k / ec);
      e.col  = 4'(k % ec);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [3:0] r, input logic [3:0] c);
    @(posedge clk); #1;
    cfg_rows = r;
    cfg_cols = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer up to nwords words; stop at done, reset or budget expiry.
  task automatic feed(input int nwords, input logic [63:0] base, input int limit, input int budget);
    int idx = 0;
    bit fin = 1'b0;
    bit acc;
    acc_count = 0;
    overrun = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      in_valid = (idx < nwords);
      in_data  = base + 64'(idx);
      @(negedge clk);
      if (reset || done) begin
        fin = 1'b1;
        break;
      end
      if (in_ready && acc_count >= limit) overrun++;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        acc_count++;
      end
    end
    in_valid = 1'b0;
    chk("feed_timeout", 64'(!fin), 64'(0));
  endtask

  // Called at the negedge where done is first seen high.
  task automatic finish_frame(input string tag);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(done), 64'(0));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int d0;
    bit to;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_enable_out", 64'(enable_out), 64'(0));
    chk("rst_data_out", data_out, 64'(0));
    chk("rst_tags", 64'({row_tag, col_tag}), 64'(0));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic 2x3 frame
    ready_in = 1'b1;
    push_exp(2, 3, 64'h0);
    do_start(4'd2, 4'd3);
    chk("basic_busy", 64'(busy), 64'(1));
    feed(6, 64'h0, 6, 100);
    finish_frame("basic");

    // Backpressure: 1x14, ready_in low for 10 cycles
    ready_in = 1'b0;
    push_exp(1, 14, 64'hA000);
    do_start(4'd1, 4'd14);
    fork
      feed(14, 64'hA000, 14, 200);
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 64'(acc_count), 64'(4));
        chk("bp_in_ready_full", 64'(in_ready), 64'(0));
        chk("bp_enable_held", 64'(enable_out), 64'(1));
        chk("bp_tag_held", 64'({row_tag, col_tag}), 64'(0));
        chk("bp_data_held", data_out, 64'hA000);
        @(posedge clk); #1;
        ready_in = 1'b1;
      end
    join
    finish_frame("bp");
    chk("bp_last_col", 64'(last_col), 64'(13));

    // Frame-size cap: 1x2 with 5 words available
    push_exp(1, 2, 64'hB000);
    do_start(4'd1, 4'd2);
    feed(5, 64'hB000, 2, 100);
    chk("cap_accepted", 64'(acc_count), 64'(2));
    chk("cap_overrun", 64'(overrun), 64'(0));
    finish_frame("cap");

    // Clamp: 15x15 -> 12x14
    push_exp(12, 14, 64'hC000);
    do_start(4'd15, 4'd15);
    feed(170, 64'hC000, 168, 600);
    chk("clamp_accepted", 64'(acc_count), 64'(168));
    chk("clamp_last_tag", 64'({last_row, last_col}), 64'({4'd11, 4'd13}));
    finish_frame("clamp");

    // Zero columns: done the cycle after start, no activity
    d0 = done_cnt;
    in_valid = 1'b1;
    do_start(4'd3, 4'd0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_handshakes", 64'({enable_out, in_ready}), 64'(0));
    @(negedge clk);
    chk("zero_done_width", 64'(done), 64'(0));
    chk("zero_done_count", 64'(done_cnt - d0), 64'(1));
    in_valid = 1'b0;

    // Mid-frame reset after 3 transfers of 2x3
    push_exp(2, 3, 64'hD000);
    d0 = mon_xfers;
    do_start(4'd2, 4'd3);
    fork
      feed(6, 64'hD000, 6, 100);
      begin
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (mon_xfers >= d0 + 3) begin
            to = 1'b0;
            break;
          end
        end
        chk("mr_wait_timeout", 64'(to), 64'(0));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'(0));
        chk("mr_enable_out", 64'(enable_out), 64'(0));
        chk("mr_data_out", data_out, 64'(0));
        chk("mr_tags", 64'({row_tag, col_tag}), 64'(0));
        chk("mr_busy_done", 64'({busy, done}), 64'(0));
      end
    join
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_fifo_empty", 64'(enable_out), 64'(0));
    push_exp(2, 3, 64'hE000);
    do_start(4'd2, 4'd3);
    feed(6, 64'hE000, 6, 100);
    finish_frame("mr_restart");

    // Start while busy is ignored
    push_exp(2, 3, 64'hF000);
    d0 = done_cnt;
    do_start(4'd2, 4'd3);
    fork
      feed(6, 64'hF000, 6, 100);
      begin
        @(posedge clk); #1;
        cfg_rows = 4'd1;
        cfg_cols = 4'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    finish_frame("swb");
    repeat (4) @(negedge clk);
    chk("swb_done_count", 64'(done_cnt - d0), 64'(1));
    chk("swb_idle", 64'(busy), 64'(0));
    chk("swb_last_tag", 64'({last_row, last_col}), 64'({4'd1, 4'd2}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
